risc16_ctrl_fsm: RTL and testbench



---
 rtl/risc16_ctrl_fsm.sv | 234 +++++++++++++++++++++++
 tb/tb_risc16_ctrl_fsm.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/risc16_ctrl_fsm.sv
// risc16_ctrl_fsm
// Multi-cycle control sequencer for the RiSC-16 datapath. It fetches over a
// req/ack memory port, holds the instruction register, decodes the rA/rB/rC
// fields and the immediate, and steps FETCH/DECODE/EXEC/MEM/WB. The register
// file, ALU and PC register sit beside it and are slaved to its outputs.
//
// Parameters:
//   WAIT_MAX  max cycles mem_req may stay high without mem_ack (0 = unlimited);
//             a timeout moves to HALT and sets err
//   RESET_IR  instruction register value after reset
//
// Ports:
//   clk, rst_n         clock (rising edge), asynchronous active-low reset
//   mem_rdata/mem_ack  memory read data and transaction-complete handshake
//   alu_eq             ALU equality flag used by BEQ
//   mem_req/mem_we     memory request (held until ack), SW write qualifier
//   mem_addr_sel       memory address source: 0 = PC, 1 = alu_out
//   ir, rA, rB, rC     instruction register and its register fields
//   imm                sign-extended ir[6:0], or {ir[9:0],6'b0} for LUI
//   MUX_tgt/MUX_rf     register-file write-data and read-port-2 selects
//   WE_rf              register-file write enable
//   alu_op/alu_src     ALU function and operand-B select
//   pc_we/pc_sel       PC load enable and next-PC select
//   instr_done         one-cycle pulse in each retiring cycle
//   halted/err         FSM in HALT, sticky timeout flag
//
// Optional build macro RISC16_RETIRE_CNT_EN adds retire_cnt[31:0], a wrapping
// count of retired instructions.

module risc16_ctrl_fsm #(
  parameter int unsigned WAIT_MAX = 0,
  parameter logic [15:0] RESET_IR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  input  logic        alu_eq,
  output logic        mem_req,
  output logic        mem_we,
  output logic        mem_addr_sel,
  output logic [15:0] ir,
  output logic [2:0]  rA,
  output logic [2:0]  rB,
  output logic [2:0]  rC,
  output logic [15:0] imm,
  output logic [1:0]  MUX_tgt,
  output logic        MUX_rf,
  output logic        WE_rf,
  output logic [1:0]  alu_op,
  output logic        alu_src,
  output logic        pc_we,
  output logic [1:0]  pc_sel,
  output logic        instr_done,
  output logic        halted,
  output logic        err
`ifdef RISC16_RETIRE_CNT_EN
  ,
  output logic [31:0] retire_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_ADDI = 3'b001,
    OP_NAND = 3'b010,
    OP_LUI  = 3'b011,
    OP_SW   = 3'b100,
    OP_LW   = 3'b101,
    OP_BEQ  = 3'b110,
    OP_JALR = 3'b111
  } opcode_t;

  localparam logic [31:0] WAIT_LAST = (WAIT_MAX == 0) ? 32'd0 : 32'(WAIT_MAX - 1);

  state_t      state;
  opcode_t     op;
  logic [31:0] wait_cnt;
  logic        timeout;

  assign op = opcode_t'(ir[15:13]);
  assign rA = ir[12:10];
  assign rB = ir[9:7];
  assign rC = ir[2:0];

  // Last permitted wait cycle: an edge here without ack ends the request.
  assign timeout = (WAIT_MAX != 0) && (wait_cnt == WAIT_LAST);

  always_comb begin
    if (op == OP_LUI) imm = {ir[9:0], 6'b000000};
    else              imm = {{9{ir[6]}}, ir[6:0]};
  end

  // Sequencer state, instruction register and the decoded selects, which are
  // loaded in DECODE and held until the next DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_FETCH;
      ir       <= RESET_IR;
      err      <= 1'b0;
      wait_cnt <= '0;
      MUX_tgt  <= '0;
      MUX_rf   <= 1'b0;
      alu_op   <= '0;
      alu_src  <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (mem_ack) begin
            ir    <= mem_rdata;
            state <= S_DECODE;
          end else if (timeout) begin
            state <= S_HALT;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        S_DECODE: begin
          MUX_rf  <= (op == OP_SW) || (op == OP_BEQ);
          alu_op  <= 2'b00;
          alu_src <= 1'b0;
          MUX_tgt <= 2'b00;
          case (op)
            OP_ADD:  MUX_tgt <= 2'b01;
            OP_ADDI: begin MUX_tgt <= 2'b01; alu_src <= 1'b1; end
            OP_NAND: begin MUX_tgt <= 2'b01; alu_op  <= 2'b01; end
            OP_LUI:  begin MUX_tgt <= 2'b01; alu_op  <= 2'b10; alu_src <= 1'b1; end
            OP_SW:   alu_src <= 1'b1;
            OP_LW:   alu_src <= 1'b1;
            OP_BEQ:  alu_op  <= 2'b11;
            OP_JALR: MUX_tgt <= 2'b10;
            default: ;
          endcase
          // JALR with a non-zero immediate field is an illegal encoding.
          if ((op == OP_JALR) && (ir[6:0] != 7'd0)) state <= S_HALT;
          else                                      state <= S_EXEC;
        end

        S_EXEC: begin
          wait_cnt <= '0;
          case (op)
            OP_BEQ:       state <= S_FETCH;
            OP_SW, OP_LW: state <= S_MEM;
            default:      state <= S_WB;
          endcase
        end

        S_MEM: begin
          if (mem_ack) begin
            wait_cnt <= '0;
            state    <= (op == OP_SW) ? S_FETCH : S_WB;
          end else if (timeout) begin
            state <= S_HALT;
            err   <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 32'd1;
          end
        end

        S_WB: begin
          wait_cnt <= '0;
          state    <= S_FETCH;
        end

        S_HALT: state <= S_HALT;

        default: state <= S_HALT;
      endcase
    end
  end

  // Strobes are decoded from state and qualified by rst_n so they fall the
  // moment reset is asserted. SW retirement and the BEQ target select follow
  // the same-cycle mem_ack / alu_eq inputs.
  always_comb begin
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr_sel = 1'b0;
    WE_rf        = 1'b0;
    pc_we        = 1'b0;
    pc_sel       = 2'b00;
    instr_done   = 1'b0;
    halted       = 1'b0;
    if (rst_n) begin
      case (state)
        S_FETCH: mem_req = 1'b1;
        S_EXEC: begin
          if (op == OP_BEQ) begin
            pc_we      = 1'b1;
            pc_sel     = alu_eq ? 2'b01 : 2'b00;
            instr_done = 1'b1;
          end
        end
        S_MEM: begin
          mem_req      = 1'b1;
          mem_addr_sel = 1'b1;
          mem_we       = (op == OP_SW);
          if ((op == OP_SW) && mem_ack) begin
            pc_we      = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_WB: begin
          WE_rf      = 1'b1;
          pc_we      = 1'b1;
          pc_sel     = (op == OP_JALR) ? 2'b10 : 2'b00;
          instr_done = 1'b1;
        end
        S_HALT:  halted = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef RISC16_RETIRE_CNT_EN
  // Retirements never occur in HALT, so the count is frozen there.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          retire_cnt <= '0;
    else if (instr_done) retire_cnt <= retire_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_risc16_ctrl_fsm.sv
module tb_risc16_ctrl_fsm;

  localparam int unsigned WAIT_MAX = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic        alu_eq;
  logic        mem_req, mem_we, mem_addr_sel;
  logic [15:0] ir, imm;
  logic [2:0]  rA, rB, rC;
  logic [1:0]  MUX_tgt, alu_op, pc_sel;
  logic        MUX_rf, WE_rf, alu_src, pc_we, instr_done, halted, err;
`ifdef RISC16_RETIRE_CNT_EN
  logic [31:0] retire_cnt;
`endif

  always #5 clk = ~clk;

  risc16_ctrl_fsm #(.WAIT_MAX(WAIT_MAX), .RESET_IR(16'h0000)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .alu_eq(alu_eq), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr_sel(mem_addr_sel), .ir(ir), .rA(rA), .rB(rB), .rC(rC),
    .imm(imm), .MUX_tgt(MUX_tgt), .MUX_rf(MUX_rf), .WE_rf(WE_rf),
    .alu_op(alu_op), .alu_src(alu_src), .pc_we(pc_we), .pc_sel(pc_sel),
    .instr_done(instr_done), .halted(halted), .err(err)
`ifdef RISC16_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int exp_retired = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One entry per clock cycle: the inputs to drive and the outputs expected.
  typedef struct {
    logic        ack;
    logic [15:0] rdata;
    logic        eq;
    logic [8:0]  strb;
    logic [5:0]  sel;
    logic [5:0]  sel_mask;
    logic [15:0] imm;
    logic        imm_chk;
    logic [8:0]  fld;
    logic        fld_chk;
    logic        err;
    string       tag;
  } ent_t;

  ent_t sb[$];

  // {mem_req, mem_addr_sel, mem_we, WE_rf, pc_we, pc_sel, instr_done, halted}
  function automatic logic [8:0] mk(input logic req, input logic asel, input logic we,
                                    input logic werf, input logic pcwe,
                                    input logic [1:0] psel, input logic done,
                                    input logic halt);
    return {req, asel, we, werf, pcwe, psel, done, halt};
  endfunction

  function automatic ent_t blank(input string tag);
    ent_t e;
    e.ack = 1'b0; e.rdata = 16'(($urandom)); e.eq = 1'b0;
    e.strb = '0; e.sel = '0; e.sel_mask = '0; e.imm = '0; e.imm_chk = 1'b0;
    e.fld = '0; e.fld_chk = 1'b0; e.err = 1'b0; e.tag = tag;
    return e;
  endfunction

  task automatic queue_instr(input string name, input logic [15:0] ins, input int fd,
                             input int md, input logic eq, input logic noise);
    ent_t e;
    logic [2:0]  op;
    logic [5:0]  sel, mask;
    logic [15:0] ximm;
    logic        ichk, retires;
    op   = ins[15:13];
    ximm = {{9{ins[6]}}, ins[6:0]};
    ichk = 1'b1;
    mask = 6'b111111;
    // sel = {MUX_tgt, MUX_rf, alu_op, alu_src}
    case (op)
      3'b000: begin sel = 6'b01_0_00_0; ichk = 1'b0; end
      3'b001: sel = 6'b01_0_00_1;
      3'b010: begin sel = 6'b01_0_01_0; ichk = 1'b0; end
      3'b011: begin sel = 6'b01_0_10_1; ximm = {ins[9:0], 6'b000000}; end
      3'b100: begin sel = 6'b00_1_00_1; mask = 6'b00_1_11_1; end
      3'b101: sel = 6'b00_0_00_1;
      3'b110: begin sel = 6'b00_1_11_0; mask = 6'b00_1_11_1; end
      default: begin sel = 6'b10_0_00_0; mask = 6'b11_1_00_0; ichk = 1'b0; end
    endcase
    for (int i = 0; i <= fd; i++) begin
      e = blank({name, ".F"});
      e.ack = (i == fd);
      if (i == fd) e.rdata = ins;
      e.strb = mk(1, 0, 0, 0, 0, 2'b00, 0, 0);
      sb.push_back(e);
    end
    e = blank({name, ".D"});
    e.ack = noise; e.eq = eq;
    e.fld = {ins[12:10], ins[9:7], ins[2:0]}; e.fld_chk = 1'b1;
    e.imm = ximm; e.imm_chk = ichk;
    sb.push_back(e);
    if (op == 3'b111 && ins[6:0] != 7'd0) return;
    retires = 1'b1;
    e = blank({name, ".E"});
    e.ack = noise; e.eq = eq;
    e.fld = {ins[12:10], ins[9:7], ins[2:0]}; e.fld_chk = 1'b1;
    e.imm = ximm; e.imm_chk = ichk; e.sel = sel; e.sel_mask = mask;
    if (op == 3'b110) e.strb = mk(0, 0, 0, 0, 1, eq ? 2'b01 : 2'b00, 1, 0);
    sb.push_back(e);
    if (op == 3'b100 || op == 3'b101) begin
      for (int i = 0; i <= md; i++) begin
        e = blank({name, ".M"});
        e.eq = eq; e.ack = (i == md);
        e.fld = {ins[12:10], ins[9:7], ins[2:0]}; e.fld_chk = 1'b1;
        e.imm = ximm; e.imm_chk = ichk; e.sel = sel; e.sel_mask = mask;
        e.strb = mk(1, 1, op == 3'b100, 0, (op == 3'b100) && (i == md), 2'b00,
                    (op == 3'b100) && (i == md), 0);
        sb.push_back(e);
      end
    end
    if (op != 3'b110 && op != 3'b100) begin
      e = blank({name, ".W"});
      e.ack = noise; e.eq = eq;
      e.fld = {ins[12:10], ins[9:7], ins[2:0]}; e.fld_chk = 1'b1;
      e.imm = ximm; e.imm_chk = ichk; e.sel = sel; e.sel_mask = mask;
      e.strb = mk(0, 0, 0, 1, 1, (op == 3'b111) ? 2'b10 : 2'b00, 1, 0);
      sb.push_back(e);
    end
    if (retires) exp_retired++;
  endtask

  task automatic queue_wait(input int n);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e = blank("WAIT.F");
      e.strb = mk(1, 0, 0, 0, 0, 2'b00, 0, 0);
      sb.push_back(e);
    end
  endtask

  task automatic queue_halt(input int n, input logic exp_err);
    ent_t e;
    for (int i = 0; i < n; i++) begin
      e = blank("HALT");
      e.ack = 1'($urandom_range(0, 1));
      e.strb = mk(0, 0, 0, 0, 0, 2'b00, 0, 1);
      e.err = exp_err;
      sb.push_back(e);
    end
  endtask

  // Called at a negedge; drives each cycle's inputs, samples 1 ns later.
  task automatic drain();
    ent_t e;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      mem_ack = e.ack; mem_rdata = e.rdata; alu_eq = e.eq;
      #1;
      check({e.tag, ".strb"},
            32'({mem_req, mem_addr_sel, mem_we, WE_rf, pc_we, pc_sel, instr_done, halted}),
            32'(e.strb));
      check({e.tag, ".err"}, 32'(err), 32'(e.err));
      if (e.sel_mask != 6'd0)
        check({e.tag, ".sel"}, 32'({MUX_tgt, MUX_rf, alu_op, alu_src} & e.sel_mask),
              32'(e.sel));
      if (e.imm_chk) check({e.tag, ".imm"}, 32'(imm), 32'(e.imm));
      if (e.fld_chk) check({e.tag, ".fld"}, 32'({rA, rB, rC}), 32'(e.fld));
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = '0; alu_eq = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst.strb",
          32'({mem_req, mem_addr_sel, mem_we, WE_rf, pc_we, pc_sel, instr_done, halted}), 0);
    check("rst.ir", 32'(ir), 32'h0000);
    check("rst.err", 32'(err), 0);
    check("rst.sel", 32'({MUX_tgt, MUX_rf, alu_op, alu_src}), 0);
    @(negedge clk);

    queue_instr("ADDI",  16'h2405, 0, 0, 1'b0, 1'b0);
    queue_instr("LW",    16'hB8FF, 1, 3, 1'b0, 1'b0);
    queue_instr("BEQ1",  16'hC482, 0, 0, 1'b1, 1'b1);
    queue_instr("BEQ0",  16'hC482, 2, 0, 1'b0, 1'b0);
    queue_instr("SW",    16'h8483, 0, 1, 1'b0, 1'b1);
    queue_instr("ADD",   16'h0483, 0, 0, 1'b1, 1'b0);
    queue_instr("NAND",  16'h4483, 1, 0, 1'b0, 1'b1);
    queue_instr("LUI",   16'h7FFF, 0, 0, 1'b0, 1'b0);
    queue_instr("JALR",  16'hFD80, 0, 0, 1'b0, 1'b1);
    queue_instr("BADJ",  16'hE001, 0, 0, 1'b0, 1'b0);
    queue_halt(3, 1'b0);
    rst_n = 1'b1;
    drain();
`ifdef RISC16_RETIRE_CNT_EN
    check("retire_cnt", retire_cnt, 32'(exp_retired));
`endif

    // Timeout: no ack in FETCH for WAIT_MAX cycles.
    #1 rst_n = 1'b0;
    #1;
    check("rst2.halted", 32'(halted), 0);
    @(negedge clk);
    queue_wait(WAIT_MAX);
    queue_halt(2, 1'b1);
    rst_n = 1'b1;
    drain();

    // Reset clears the sticky err.
    #1 rst_n = 1'b0;
    #1;
    check("rst3.err", 32'(err), 0);
    check("rst3.halted", 32'(halted), 0);
    @(negedge clk);

    // Reset asserted in the middle of a fetch wait drops mem_req at once.
    queue_wait(2);
    rst_n = 1'b1;
    drain();
    mem_ack = 1'b0;
    #2;
    check("midwait.req_before", 32'(mem_req), 1);
    rst_n = 1'b0;
    #1;
    check("midwait.req_after", 32'(mem_req), 0);
    check("midwait.err", 32'(err), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
